pc_sequencer: RTL and testbench

Program-counter sequencer that generates the word address driven into the instruction fetch stage's `pc_address` input each cycle. It holds the architectural fetch PC, advances it by one word per cycle, and redirects on taken branches (from EX) and jumps (from ID). It also holds on pipeline stall and parks the front end on halt. Sits directly upstream of instruction fetch; its registered PC is the fetch stage's address source.

---
 rtl/pc_seq_pkg.sv | 15 +
 rtl/pc_next_mux.sv | 30 +++
 rtl/pc_sequencer.sv | 123 ++++++++++++
 tb/tb_pc_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the fetch program-counter sequencer.
package pc_seq_pkg;

   typedef enum logic [1:0] {
      StBoot = 2'd0,
      StRun  = 2'd1,
      StHalt = 2'd2,
      StTrap = 2'd3
   } pc_seq_state_e;

   localparam int unsigned PC_WIDTH_DEF = 11;
   localparam logic [PC_WIDTH_DEF-1:0] RESET_VECTOR_DEF = '0;
   localparam logic [PC_WIDTH_DEF-1:0] PC_MAX = '1;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC priority select: branch, then jump, then stall hold, else increment.
module pc_next_mux #(
   parameter int unsigned PC_WIDTH = 11
) (
   input  logic [PC_WIDTH-1:0] pc,
   input  logic                stall,
   input  logic                branch_taken,
   input  logic [PC_WIDTH-1:0] branch_target,
   input  logic                jump,
   input  logic [PC_WIDTH-1:0] jump_target,
   output logic [PC_WIDTH-1:0] next_pc,
   output logic                redirect
);

   always_comb begin
      next_pc  = pc + PC_WIDTH'(1);
      redirect = 1'b0;
      // The branch is older than the jump in ID, so it wins.
      if (branch_taken) begin
         next_pc  = branch_target;
         redirect = 1'b1;
      end else if (jump) begin
         next_pc  = jump_target;
         redirect = 1'b1;
      end else if (stall) begin
         next_pc = pc;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: BOOT/RUN/HALT FSM with registered fetch address and flush.
// PC_WRAP_TRAP_EN: trap on PC overflow instead of wrapping to zero.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int unsigned          PC_WIDTH     = PC_WIDTH_DEF,
   parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = PC_WIDTH'(RESET_VECTOR_DEF)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall,
   input  logic                branch_taken,
   input  logic [PC_WIDTH-1:0] branch_target,
   input  logic                jump,
   input  logic [PC_WIDTH-1:0] jump_target,
   input  logic                halt_req,
   input  logic                resume,
   output logic [PC_WIDTH-1:0] pc_address,
   output logic                pc_valid,
   output logic                flush,
   output logic                halted,
   output logic                wrap_err
);

   pc_seq_state_e       state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [PC_WIDTH-1:0] mux_pc;
   logic                redirect;
   logic                flush_q, flush_d;
   logic                valid_q, halted_q;

   pc_next_mux #(
      .PC_WIDTH(PC_WIDTH)
   ) u_next_mux (
      .pc           (pc_q),
      .stall        (stall),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .jump         (jump),
      .jump_target  (jump_target),
      .next_pc      (mux_pc),
      .redirect     (redirect)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      flush_d = 1'b0;
      case (state_q)
         StBoot: state_d = StRun;
         StRun: begin
            if (halt_req) begin
               // Park on the redirect target if there is one, never increment.
               state_d = StHalt;
               if (redirect) begin
                  pc_d    = mux_pc;
                  flush_d = 1'b1;
               end
            end else begin
               pc_d    = mux_pc;
               flush_d = redirect;
`ifdef PC_WRAP_TRAP_EN
               if (!redirect && !stall && (pc_q == {PC_WIDTH{1'b1}})) begin
                  state_d = StTrap;
                  pc_d    = pc_q;
               end
`endif
            end
         end
         StHalt: begin
            if (redirect) begin
               pc_d    = mux_pc;
               flush_d = 1'b1;
            end
            if (resume && !halt_req) begin
               state_d = StRun;
            end
         end
`ifdef PC_WRAP_TRAP_EN
         StTrap: state_d = StTrap;
`endif
         default: state_d = StBoot;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StBoot;
         pc_q     <= RESET_VECTOR;
         flush_q  <= 1'b0;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         flush_q  <= flush_d;
         valid_q  <= (state_d == StRun);
         halted_q <= (state_d == StHalt);
      end
   end

`ifdef PC_WRAP_TRAP_EN
   logic wrap_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         wrap_q <= 1'b0;
      end else begin
         wrap_q <= (state_d == StTrap);
      end
   end

   assign wrap_err = wrap_q;
`else
   assign wrap_err = 1'b0;
`endif

   assign pc_address = pc_q;
   assign pc_valid   = valid_q;
   assign flush      = flush_q;
   assign halted     = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus random bench for pc_sequencer against a behavioural fetch-PC model.
module tb_pc_sequencer;

   localparam int unsigned W  = 11;
   localparam int unsigned RV = 'h010;
   localparam int unsigned PC_SPAN = 1 << W;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         stall = 1'b0;
   logic         branch_taken = 1'b0;
   logic [W-1:0] branch_target = '0;
   logic         jump = 1'b0;
   logic [W-1:0] jump_target = '0;
   logic         halt_req = 1'b0;
   logic         resume = 1'b0;
   logic [W-1:0] pc_address;
   logic         pc_valid;
   logic         flush;
   logic         halted;
   logic         wrap_err;

   int errors = 0;
   int checks = 0;

   // Model: fetch mode flags and the PC as a plain integer.
   bit          m_booting = 1'b1;
   bit          m_running = 1'b0;
   bit          m_parked  = 1'b0;
   bit          m_trapped = 1'b0;
   bit          m_flush   = 1'b0;
   int unsigned m_pc      = RV;

   pc_sequencer #(
      .PC_WIDTH    (W),
      .RESET_VECTOR(W'(RV))
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .jump         (jump),
      .jump_target  (jump_target),
      .halt_req     (halt_req),
      .resume       (resume),
      .pc_address   (pc_address),
      .pc_valid     (pc_valid),
      .flush        (flush),
      .halted       (halted),
      .wrap_err     (wrap_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Applies the sampled inputs of one clock edge to the model.
   task automatic model_edge();
      bit          redir;
      int unsigned tgt;
      m_flush = 1'b0;
      if (rst) begin
         m_booting = 1'b1; m_running = 1'b0; m_parked = 1'b0; m_trapped = 1'b0;
         m_pc = RV;
      end else if (m_booting) begin
         m_booting = 1'b0; m_running = 1'b1;
      end else if (!m_trapped) begin
         redir = branch_taken || jump;
         tgt   = branch_taken ? int'(branch_target) : int'(jump_target);
         if (redir) begin
            m_pc = tgt;
            m_flush = 1'b1;
         end
         if (m_running) begin
            if (halt_req) begin
               m_running = 1'b0; m_parked = 1'b1;
            end else if (!redir && !stall) begin
               if (m_pc == PC_SPAN - 1) begin
`ifdef PC_WRAP_TRAP_EN
                  m_running = 1'b0; m_trapped = 1'b1;
`else
                  m_pc = 0;
`endif
               end else begin
                  m_pc = m_pc + 1;
               end
            end
         end else if (m_parked && resume && !halt_req) begin
            m_parked = 1'b0; m_running = 1'b1;
         end
      end
   endtask

   task automatic step(input logic r, input logic s, input logic bt, input int unsigned btg,
                       input logic j, input int unsigned jtg, input logic hr, input logic rs);
      rst = r; stall = s; branch_taken = bt; branch_target = W'(btg);
      jump = j; jump_target = W'(jtg); halt_req = hr; resume = rs;
      @(posedge clk);
      model_edge();
      #1;
      chk("pc_address", 32'(pc_address), m_pc);
      chk("pc_valid", 32'(pc_valid), 32'(m_running));
      chk("flush", 32'(flush), 32'(m_flush));
      chk("halted", 32'(halted), 32'(m_parked));
      chk("wrap_err", 32'(wrap_err), 32'(m_trapped));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      // Reset and boot: one BOOT cycle, then sequential fetch from the vector.
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      chk("rst_pc", 32'(pc_address), 'h010);
      chk("rst_valid", 32'(pc_valid), 0);
      idle(1);
      chk("boot_pc0", 32'(pc_address), 'h010);
      chk("boot_valid", 32'(pc_valid), 1);
      idle(2);
      chk("boot_pc2", 32'(pc_address), 'h012);

      // Stall holds for three cycles, then resumes incrementing.
      step(0, 0, 0, 0, 1, 'h020, 0, 0);
      chk("jump_flush", 32'(flush), 1);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 0, 0);
      chk("stall_hold", 32'(pc_address), 'h020);
      idle(1);
      chk("stall_release", 32'(pc_address), 'h021);

      // Branch beats jump and stall together.
      step(0, 1, 1, 'h100, 1, 'h200, 0, 0);
      chk("branch_pc", 32'(pc_address), 'h100);
      chk("branch_flush", 32'(flush), 1);
      idle(1);
      chk("branch_next", 32'(pc_address), 'h101);
      chk("flush_one_cycle", 32'(flush), 0);

      // Halt, redirect while halted, resume.
      step(0, 0, 0, 0, 1, 'h030, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1, 0);
      chk("halt_halted", 32'(halted), 1);
      chk("halt_pc", 32'(pc_address), 'h030);
      idle(5);
      chk("halt_hold_pc", 32'(pc_address), 'h030);
      step(0, 0, 0, 0, 1, 'h040, 0, 0);
      chk("halt_jump_pc", 32'(pc_address), 'h040);
      chk("halt_jump_halted", 32'(halted), 1);
      step(0, 0, 0, 0, 0, 0, 1, 1);
      chk("resume_ignored", 32'(halted), 1);
      step(0, 0, 0, 0, 0, 0, 0, 1);
      chk("resume_valid", 32'(pc_valid), 1);
      chk("resume_pc", 32'(pc_address), 'h040);
      idle(1);
      chk("resume_next", 32'(pc_address), 'h041);

      // Top of the address space.
      step(0, 0, 0, 0, 1, 'h7FE, 0, 0);
      idle(1);
      chk("wrap_max", 32'(pc_address), 'h7FF);
      idle(1);
`ifdef PC_WRAP_TRAP_EN
      chk("trap_pc", 32'(pc_address), 'h7FF);
      chk("trap_err", 32'(wrap_err), 1);
      step(0, 0, 1, 'h123, 0, 0, 0, 1);
      chk("trap_sticky", 32'(pc_address), 'h7FF);
`else
      chk("wrap_zero", 32'(pc_address), 'h000);
      chk("wrap_err_tied", 32'(wrap_err), 0);
`endif
      step(1, 0, 0, 0, 0, 0, 0, 0);
      idle(1);

      // Reset during HALT with a branch pending.
      step(0, 0, 0, 0, 0, 0, 1, 0);
      step(1, 0, 1, 'h555, 0, 0, 0, 0);
      chk("rst_halt_pc", 32'(pc_address), 'h010);
      chk("rst_halt_halted", 32'(halted), 0);
      chk("rst_halt_flush", 32'(flush), 0);
      chk("rst_halt_valid", 32'(pc_valid), 0);
      idle(1);
      chk("rst_halt_boot", 32'(pc_address), 'h010);

      // Random traffic; targets biased toward the top of the range.
      for (int i = 0; i < 600; i++) begin
         int unsigned bt_t, j_t;
         bt_t = ($urandom_range(0, 3) == 0) ? $urandom_range(PC_SPAN - 3, PC_SPAN - 1)
                                            : $urandom_range(0, PC_SPAN - 1);
         j_t  = ($urandom_range(0, 3) == 0) ? $urandom_range(PC_SPAN - 3, PC_SPAN - 1)
                                            : $urandom_range(0, PC_SPAN - 1);
         step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 7) == 0), bt_t, ($urandom_range(0, 7) == 0), j_t,
              ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
